// File: rtl/instruction_fetch_unit.sv
// RV32I instruction fetch: owns the PC and keeps one imem read in flight.
// Presents a held instruction to decode and handles redirects and stalls.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        inst_valid,
  output logic        misaligned_fault
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic        fault_q, fault_d;
  logic        kill_q, kill_d;

  logic redir_ok;
  logic redir_bad;
  logic accept;

  assign redir_bad = redirect_valid & (|redirect_target[1:0]);
  assign redir_ok  = redirect_valid & ~(|redirect_target[1:0]);
  assign accept    = req_q & imem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      fault_q <= fault_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (redir_bad)   state_d = S_FAULT;
        else if (accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redir_bad) begin
          state_d = S_FAULT;
        end else if (imem_rvalid) begin
          state_d = (kill_q | redir_ok) ? S_FETCH : S_HOLD;
        end
      end
      S_HOLD: begin
        if (redir_bad)                state_d = S_FAULT;
        else if (redir_ok || !stall)  state_d = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    fault_d = fault_q;
    kill_d  = kill_q;
    unique case (state_q)
      S_FETCH: begin
        // An accepted old-pc request must be drained before refetching.
        if (redir_ok) begin
          pc_d   = redirect_target;
          kill_d = accept;
        end
      end
      S_WAIT: begin
        if (redir_ok) begin
          pc_d   = redirect_target;
          kill_d = ~imem_rvalid;
        end else if (imem_rvalid) begin
          kill_d = 1'b0;
          if (!kill_q) begin
            inst_d  = imem_rdata;
            valid_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (redir_ok) begin
          pc_d    = redirect_target;
          valid_d = 1'b0;
          inst_d  = NOP_INST;
        end else if (!stall) begin
          pc_d    = pc_q + 32'd4;
          valid_d = 1'b0;
          inst_d  = NOP_INST;
        end
      end
      S_FAULT: ;
      default: ;
    endcase
    if (redir_bad && state_q != S_FAULT) begin
      fault_d = 1'b1;
      valid_d = 1'b0;
      inst_d  = NOP_INST;
      kill_d  = 1'b0;
    end
    req_d = (state_d == S_FETCH);
  end

  assign imem_req         = req_q;
  assign imem_addr        = pc_q;
  assign pc               = pc_q;
  assign pc_plus4         = pc_q + 32'd4;
  assign instruction      = inst_q;
  assign inst_valid       = valid_q;
  assign misaligned_fault = fault_q;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Upstream front end of the RV32I core. It owns the program counter and issues one instruction-memory read at a time. It captures the returned word and presents a stable instruction, its PC, and a valid flag to decode. Decode includes the immediate generator, which consumes `instruction` directly. Branch and jump redirects from execute override sequential fetch; stalls hold the presented instruction.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset (must be 4-byte aligned)
- NOP_INST, 32'h00000013, value driven on `instruction` while nothing valid (ADDI x0,x0,0)

Ports:
- clk  in  1  core clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  read address (= pc while requesting)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  read data
- stall  in  1  decode cannot accept the presented instruction
- redirect_valid  in  1  taken branch / JAL / JALR
- redirect_target  in  32  new PC
- instruction  out  32  fetched instruction to decode
- pc  out  32  address of `instruction`
- pc_plus4  out  32  pc + 4, modulo 2^32
- inst_valid  out  1  `instruction` and `pc` are valid
- misaligned_fault  out  1  sticky: redirect_target[1:0] != 0

Behaviour:
- Reset (async, any state): pc=RESET_PC, instruction=NOP_INST, inst_valid=0, imem_req=0, misaligned_fault=0, kill=0, state=FETCH. All outputs are registered except imem_addr (=pc) and pc_plus4 (=pc+4).
- Exactly one outstanding memory request. FSM states: FETCH, WAIT, HOLD, FAULT.
- FETCH
  - imem_req=1, imem_addr=pc.
  - imem_ready=1 → WAIT. Otherwise stay in FETCH, holding the address stable.
- WAIT
  - imem_req=0.
  - imem_rvalid=1 with kill=0 → instruction<=imem_rdata, inst_valid<=1, → HOLD.
  - imem_rvalid=1 with kill=1 → discard data, kill<=0, → FETCH.
- HOLD
  - inst_valid=1; instruction and pc held stable.
  - stall=0 → consume: pc<=pc+4, inst_valid<=0, instruction<=NOP_INST, → FETCH.
  - stall=1 → hold.
- Redirect (redirect_valid=1) has priority over stall and sequential advance in every state except FAULT.
  - target[1:0]!=0 → misaligned_fault<=1, inst_valid<=0, imem_req held 0, → FAULT.
  - FETCH: pc<=target. If imem_ready=1 in the same cycle, the old-pc request was accepted: kill<=1, → WAIT. Otherwise stay in FETCH.
  - WAIT without rvalid: pc<=target, kill<=1, stay in WAIT.
  - WAIT with rvalid in the same cycle: data dropped, pc<=target, → FETCH.
  - HOLD: pc<=target, inst_valid<=0, instruction<=NOP_INST, → FETCH.
- FAULT is terminal until reset: imem_req=0, inst_valid=0, misaligned_fault=1. All inputs are ignored.
- imem_rvalid outside WAIT is ignored.
- Latency: request accepted at cycle N, earliest rvalid at N+1, inst_valid=1 from N+2. Peak throughput is one instruction per 3 cycles.
- PC arithmetic wraps: pc=32'hFFFFFFFC advances to 32'h00000000. No fault on wrap.

Test Plan:
- Reset release, memory always ready, rvalid one cycle after accept, rdata=32'h00500093 → imem_addr=0x0, then 0x4, 0x8; inst_valid pulses each 3 cycles with pc=0x0,0x4,0x8; before the first fetch, instruction=32'h00000013.
- stall=1 for 5 cycles while in HOLD with pc=0x4 → instruction and pc=0x4 stable, imem_req=0 throughout; after stall drops, next imem_addr=0x8.
- redirect_valid=1, target=0x100, in WAIT (rvalid arrives 2 cycles later with 0xDEADBEEF) → 0xDEADBEEF never shown, inst_valid stays 0, next imem_addr=0x100.
- imem_ready held 0 for 4 cycles in FETCH → imem_req=1 and imem_addr constant; redirect to 0x40 during the wait → imem_addr switches to 0x40 next cycle, no kill.
- Redirect target=0x102 → misaligned_fault=1 next cycle, imem_req=0 thereafter regardless of inputs; async reset mid-state clears it immediately to pc=RESET_PC.
- Redirect to 0xFFFFFFFC, then consume → next imem_addr=0x00000000; pc_plus4 at pc=0xFFFFFFFC reads 0x00000000.
